// File: rtl/scu_dsp_dma_ctrl_if.sv
// scu_dsp_dma_ctrl_if: SCU bus request/ack port between the DSP DMA controller and the bus arbiter
interface scu_dsp_dma_ctrl_if #(
    parameter int AW = 25
);
    logic          BUS_REQ;
    logic          BUS_WE;
    logic [AW+1:0] BUS_A;
    logic [31:0]   BUS_DO;
    logic [31:0]   BUS_DI;
    logic          BUS_ACK;
    modport master (output BUS_REQ, BUS_WE, BUS_A, BUS_DO, input BUS_DI, BUS_ACK);
    modport slave  (input BUS_REQ, BUS_WE, BUS_A, BUS_DO, output BUS_DI, BUS_ACK);
endinterface

// File: rtl/scu_dsp_dma_ctrl.sv
// scu_dsp_dma_ctrl: DSP DMA word sequencer; define SCU_DSP_DMA_HOLD_EN to honour the DMAW HOLD bit
module scu_dsp_dma_ctrl #(
    parameter int AW      = 25,
    parameter int END_LEN = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE_R,
    input  logic [31:0]        DSO,
    input  logic               RA0W,
    input  logic               WA0W,
    input  logic               DMAW,
    input  logic               DSP_DMA_REQ,
    input  logic               DSP_DMA_LAST,
    input  logic [31:0]        DSP_DMA_DO,
    output logic [31:0]        DSP_DMA_DI,
    output logic               DSP_DMA_ACK,
    output logic               DSP_DMA_END,
    scu_dsp_dma_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_BUS, S_ACK, S_WAIT, S_END} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] ra0_q, ra0_d, wa0_q, wa0_d, ptr_q, ptr_d, step;
    logic          dir_q, dir_d, hold_q, hold_d, hold_new, dir_new, wb;
    logic [2:0]    add_q, add_d;
    logic [31:0]   di_q, di_d, do_q, do_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          unused_dso;
`ifdef SCU_DSP_DMA_HOLD_EN
    assign hold_new = DSO[14];
`else
    assign hold_new = 1'b0;
`endif
    assign unused_dso = ^DSO[31:AW];
    assign dir_new = (state_q == S_IDLE && DMAW) ? DSO[12] : dir_q;
    assign step = dir_q ? (add_q == 3'd0 ? '0 : AW'(1) << (add_q - 3'd1)) : AW'(add_q[0]);
    // Pointer write-back happens on the first END cycle; a direct register load still overrides it.
    assign wb = state_q == S_END && cnt_q == 8'd0 && !hold_q;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        di_d    = di_q;
        do_d    = do_q;
        dir_d   = (state_q == S_IDLE && DMAW) ? DSO[12] : dir_q;
        hold_d  = (state_q == S_IDLE && DMAW) ? hold_new : hold_q;
        add_d   = (state_q == S_IDLE && DMAW) ? DSO[17:15] : add_q;
        cnt_d   = state_q == S_END ? cnt_q + 8'd1 : 8'd0;
        ra0_d   = RA0W ? DSO[AW-1:0] : (wb && !dir_q) ? ptr_q : ra0_q;
        wa0_d   = WA0W ? DSO[AW-1:0] : (wb && dir_q) ? ptr_q : wa0_q;
        case (state_q)
            S_IDLE: if (DSP_DMA_REQ) begin
                state_d = S_BUS;
                ptr_d   = dir_new ? wa0_q : ra0_q;
                do_d    = DSP_DMA_DO;
            end
            S_BUS: if (bus.BUS_ACK) begin
                state_d = S_ACK;
                ptr_d   = ptr_q + step;
                di_d    = dir_q ? di_q : bus.BUS_DI;
            end
            S_ACK:  state_d = CE_R ? (DSP_DMA_LAST ? S_END : S_WAIT) : S_ACK;
            S_WAIT: if (DSP_DMA_REQ) begin
                state_d = S_BUS;
                do_d    = DSP_DMA_DO;
            end
            S_END:  state_d = cnt_q == 8'(END_LEN - 1) ? S_IDLE : S_END;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ra0_q   <= '0;
            wa0_q   <= '0;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
            hold_q  <= 1'b0;
            add_q   <= '0;
            di_q    <= '0;
            do_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra0_q   <= ra0_d;
            wa0_q   <= wa0_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            add_q   <= add_d;
            di_q    <= di_d;
            do_q    <= do_d;
            cnt_q   <= cnt_d;
        end
    end
    assign DSP_DMA_DI  = di_q;
    assign DSP_DMA_ACK = state_q == S_ACK;
    assign DSP_DMA_END = state_q == S_END;
    assign bus.BUS_REQ = state_q == S_BUS;
    assign bus.BUS_WE  = state_q == S_BUS && dir_q;
    assign bus.BUS_A   = {ptr_q, 2'b00};
    assign bus.BUS_DO  = do_q;
endmodule

// File: tb/tb_scu_dsp_dma_ctrl.sv
// tb_scu_dsp_dma_ctrl: vector table, directed corner sequences and random transfers against a word-level model
module tb_scu_dsp_dma_ctrl;
    localparam int AW = 25;
`ifdef SCU_DSP_DMA_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    logic        CLK = 1'b0;
    logic        RST, CE_R, RA0W, WA0W, DMAW, REQ, LAST, ACK, END_S;
    logic [31:0] DSO, DO, DI;
    scu_dsp_dma_ctrl_if #(.AW(AW)) bus ();
    scu_dsp_dma_ctrl #(.AW(AW), .END_LEN(2)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .DSO(DSO), .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW),
        .DSP_DMA_REQ(REQ), .DSP_DMA_LAST(LAST), .DSP_DMA_DO(DO), .DSP_DMA_DI(DI),
        .DSP_DMA_ACK(ACK), .DSP_DMA_END(END_S), .bus(bus)
    );
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] init;
        bit          dir;
        int          add;
        bit          hold;
        int          nw;
        int          delay;
        int          ce;
        logic [26:0] a_first;
        logic [26:0] a_last;
        logic [24:0] reg_exp;
    } vec_t;
    vec_t vt[7];

    int            checks = 0, errors = 0, cyc = 0, ce_per = 1;
    logic [AW-1:0] m_ra0, m_wa0;
    bit            m_dir, m_hold;
    logic [2:0]    m_add;
    logic [31:0]   m_di;
    logic [AW+1:0] first_a, last_a;

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
        CE_R = (cyc % ce_per) == 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Word step in longwords, straight from the command encoding.
    function automatic logic [AW-1:0] step_of(bit dir, logic [2:0] add);
        int s;
        s = dir ? (add == 3'd0 ? 0 : 2 ** (int'(add) - 1)) : int'(add) % 2;
        return AW'(s);
    endfunction

    function automatic logic [31:0] cmd_word(bit dir, int add, bit hold);
        logic [31:0] w;
        w = $urandom;
        w[12] = dir;
        w[14] = hold;
        w[17:15] = 3'(add);
        return w;
    endfunction

    task automatic load(input bit wa, input logic [31:0] v);
        DSO = v;
        WA0W = wa;
        RA0W = !wa;
        tick;
        RA0W = 1'b0;
        WA0W = 1'b0;
        if (wa) m_wa0 = v[AW-1:0];
        else m_ra0 = v[AW-1:0];
    endtask

    task automatic cmd(input bit dir, input int add, input bit hold);
        DSO = cmd_word(dir, add, hold);
        DMAW = 1'b1;
        tick;
        DMAW = 1'b0;
        m_dir = dir;
        m_add = 3'(add);
        m_hold = hold & HOLD_EN;
        chk("dmaw_no_bus", 32'(bus.BUS_REQ), 0);
    endtask

    // act: -1 random gap activity, 0 RA0W, 1 WA0W, 2 DMAW, 3 stray BUS_ACK, 4 nothing
    task automatic xfer(input int nw, input int delay, input int act, input bit clash, input bit wc, input logic [31:0] cw);
        logic [AW-1:0] p;
        logic [31:0]   wd, rd, v;
        int            n, a;
        if (wc) begin
            DSO = cw;
            DMAW = 1'b1;
            m_dir = cw[12];
            m_add = cw[17:15];
            m_hold = cw[14] & HOLD_EN;
        end
        p = m_dir ? m_wa0 : m_ra0;
        for (int w = 0; w < nw; w++) begin
            DO = $urandom;
            wd = DO;
            REQ = 1'b1;
            tick;
            REQ = 1'b0;
            DMAW = 1'b0;
            DO = $urandom;
            chk("bus_req_rise", 32'(bus.BUS_REQ), 1);
            if (w == 0) first_a = bus.BUS_A;
            last_a = bus.BUS_A;
            for (int k = 0; k <= delay; k++) begin
                chk("bus_req_hold", 32'(bus.BUS_REQ), 1);
                chk("bus_a", 32'(bus.BUS_A), 32'({p, 2'b00}));
                chk("bus_we", 32'(bus.BUS_WE), 32'(m_dir));
                if (m_dir) chk("bus_do", bus.BUS_DO, wd);
                if (k < delay) tick;
            end
            rd = $urandom;
            bus.BUS_DI = rd;
            bus.BUS_ACK = 1'b1;
            LAST = (w == nw - 1);
            tick;
            bus.BUS_ACK = 1'b0;
            bus.BUS_DI = $urandom;
            if (!m_dir) m_di = rd;
            p = p + step_of(m_dir, m_add);
            chk("bus_req_fall", 32'(bus.BUS_REQ), 0);
            n = 0;
            while (!CE_R && n < 64) begin
                chk("ack_hold", 32'(ACK), 1);
                chk("dsp_di", DI, m_di);
                tick;
                n++;
            end
            if (n >= 64) begin
                checks++;
                errors++;
                $display("FAIL ce_r_timeout: ACK still waiting after %0d cycles, required a CE_R cycle", n);
            end
            chk("ack_ce", 32'(ACK), 1);
            chk("dsp_di", DI, m_di);
            tick;
            LAST = 1'b0;
            chk("ack_drop", 32'(ACK), 0);
            if (w < nw - 1) begin
                a = act < 0 ? ($urandom_range(0, 1) != 0 ? int'($urandom_range(0, 3)) : 4) : act;
                v = $urandom;
                if (a != 4) begin
                    DSO = v;
                    RA0W = a == 0;
                    WA0W = a == 1;
                    DMAW = a == 2;
                    bus.BUS_ACK = a == 3;
                    bus.BUS_DI = v;
                    tick;
                    RA0W = 1'b0;
                    WA0W = 1'b0;
                    DMAW = 1'b0;
                    bus.BUS_ACK = 1'b0;
                    if (a == 0) m_ra0 = v[AW-1:0];
                    if (a == 1) m_wa0 = v[AW-1:0];
                    chk("wait_no_bus", 32'(bus.BUS_REQ), 0);
                    chk("wait_no_ack", 32'(ACK), 0);
                    chk("wait_di", DI, m_di);
                end
            end
        end
        chk("end_1", 32'(END_S), 1);
        chk("end_di", DI, m_di);
        if (!m_hold) begin
            if (m_dir) m_wa0 = p;
            else m_ra0 = p;
        end
        if (clash) begin
            v = $urandom;
            DSO = v;
            WA0W = m_dir;
            RA0W = !m_dir;
            if (m_dir) m_wa0 = v[AW-1:0];
            else m_ra0 = v[AW-1:0];
        end
        tick;
        RA0W = 1'b0;
        WA0W = 1'b0;
        chk("end_2", 32'(END_S), 1);
        tick;
        chk("end_low", 32'(END_S), 0);
        chk("ra0", 32'(dut.ra0_q), 32'(m_ra0));
        chk("wa0", 32'(dut.wa0_q), 32'(m_wa0));
    endtask

    initial begin
        bit rdir, rhold;
        int radd;
        vt[0] = '{32'h100, 1'b0, 1, 1'b0, 3, 2, 1, 27'h400, 27'h408, 25'h103};
        vt[1] = '{32'h20, 1'b1, 3, 1'b0, 2, 1, 1, 27'h80, 27'h90, 25'h28};
        vt[2] = '{32'h20, 1'b1, 3, 1'b1, 2, 1, 1, 27'h80, 27'h90, HOLD_EN ? 25'h20 : 25'h28};
        vt[3] = '{32'h1FFFFFF, 1'b0, 1, 1'b0, 2, 0, 1, 27'h7FFFFFC, 27'h0, 25'h1};
        vt[4] = '{32'h55, 1'b0, 0, 1'b0, 1, 5, 4, 27'h154, 27'h154, 25'h55};
        vt[5] = '{32'h1FFFFF0, 1'b1, 7, 1'b0, 2, 3, 3, 27'h7FFFFC0, 27'hC0, 25'h70};
        vt[6] = '{32'h10, 1'b1, 0, 1'b0, 3, 0, 2, 27'h40, 27'h40, 25'h10};
        {RST, CE_R, RA0W, WA0W, DMAW, REQ, LAST} = '0;
        DSO = '0;
        DO = '0;
        bus.BUS_ACK = 1'b0;
        bus.BUS_DI = '0;
        {m_ra0, m_wa0, m_add, m_di} = '0;
        m_dir = 1'b0;
        m_hold = 1'b0;
        RST = 1'b1;
        tick;
        tick;
        RST = 1'b0;
        chk("rst_bus_req", 32'(bus.BUS_REQ), 0);
        chk("rst_bus_we", 32'(bus.BUS_WE), 0);
        chk("rst_bus_a", 32'(bus.BUS_A), 0);
        chk("rst_bus_do", bus.BUS_DO, 0);
        chk("rst_di", DI, 0);
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_end", 32'(END_S), 0);

        for (int i = 0; i < 7; i++) begin
            ce_per = vt[i].ce;
            load(vt[i].dir, vt[i].init);
            cmd(vt[i].dir, vt[i].add, vt[i].hold);
            xfer(vt[i].nw, vt[i].delay, 4, 1'b0, 1'b0, 32'h0);
            chk("vec_first_a", 32'(first_a), 32'(vt[i].a_first));
            chk("vec_last_a", 32'(last_a), 32'(vt[i].a_last));
            chk("vec_reg", vt[i].dir ? 32'(dut.wa0_q) : 32'(dut.ra0_q), 32'(vt[i].reg_exp));
        end

        // DMAW together with the first REQ: the new command must set direction and step.
        ce_per = 1;
        cmd(1'b0, 1, 1'b0);
        load(1'b1, 32'h300);
        xfer(2, 1, 4, 1'b0, 1'b1, cmd_word(1'b1, 2, 1'b0));
        chk("dmaw_req_first_a", 32'(first_a), 32'hC00);
        // Register load coinciding with END write-back wins.
        load(1'b0, 32'h40);
        cmd(1'b0, 1, 1'b0);
        xfer(2, 0, 4, 1'b1, 1'b0, 32'h0);
        // WA0W and DMAW mid-transfer: pointer and command unaffected, WA0 keeps the loaded value.
        xfer(3, 1, 1, 1'b0, 1'b0, 32'h0);
        xfer(3, 0, 2, 1'b0, 1'b0, 32'h0);
        xfer(2, 0, 3, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a bus cycle.
        cmd(1'b1, 4, 1'b0);
        REQ = 1'b1;
        tick;
        REQ = 1'b0;
        chk("pre_rst_bus_req", 32'(bus.BUS_REQ), 1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        {m_ra0, m_wa0, m_add, m_di} = '0;
        m_dir = 1'b0;
        m_hold = 1'b0;
        chk("midrst_bus_req", 32'(bus.BUS_REQ), 0);
        chk("midrst_bus_we", 32'(bus.BUS_WE), 0);
        chk("midrst_bus_a", 32'(bus.BUS_A), 0);
        chk("midrst_bus_do", bus.BUS_DO, 0);
        chk("midrst_di", DI, 0);
        chk("midrst_ack", 32'(ACK), 0);
        chk("midrst_end", 32'(END_S), 0);
        bus.BUS_ACK = 1'b1;
        bus.BUS_DI = 32'hDEAD_BEEF;
        tick;
        bus.BUS_ACK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_no_end", 32'(END_S), 0);
            chk("post_rst_no_ack", 32'(ACK), 0);
            chk("post_rst_di", DI, 0);
            tick;
        end
        chk("post_rst_ra0", 32'(dut.ra0_q), 0);
        chk("post_rst_wa0", 32'(dut.wa0_q), 0);
        xfer(1, 0, 4, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            ce_per = $urandom_range(1, 4);
            if ($urandom_range(0, 1) != 0) load(1'($urandom_range(0, 1)), $urandom);
            rdir = 1'($urandom_range(0, 1));
            rhold = 1'($urandom_range(0, 1));
            radd = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0)
                xfer($urandom_range(1, 4), $urandom_range(0, 4), -1, $urandom_range(0, 3) == 0, 1'b1, cmd_word(rdir, radd, rhold));
            else begin
                cmd(rdir, radd, rhold);
                xfer($urandom_range(1, 4), $urandom_range(0, 4), -1, $urandom_range(0, 3) == 0, 1'b0, 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
